// File: rtl/map_color_pkg.sv
// Shared constants for the 3x3 map-coloring solver: region indices, FSM states,
// the 13-edge adjacency list and the per-region lower-index neighbor masks.
package map_color_pkg;
    localparam int NUM_REGIONS = 9;
    localparam int NUM_EDGES   = 13;
    localparam int IDX_W       = 4;

    localparam logic [IDX_W-1:0] REG_A = 4'd0;
    localparam logic [IDX_W-1:0] REG_B = 4'd1;
    localparam logic [IDX_W-1:0] REG_C = 4'd2;
    localparam logic [IDX_W-1:0] REG_D = 4'd3;
    localparam logic [IDX_W-1:0] REG_E = 4'd4;
    localparam logic [IDX_W-1:0] REG_F = 4'd5;
    localparam logic [IDX_W-1:0] REG_G = 4'd6;
    localparam logic [IDX_W-1:0] REG_H = 4'd7;
    localparam logic [IDX_W-1:0] REG_I = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRY,
        ST_BACKTRACK,
        ST_DONE
    } state_e;

    localparam logic [IDX_W-1:0] EDGE_U [NUM_EDGES] = '{
        REG_A, REG_A, REG_B, REG_B, REG_C, REG_D, REG_D,
        REG_E, REG_E, REG_E, REG_F, REG_G, REG_H
    };
    localparam logic [IDX_W-1:0] EDGE_V [NUM_EDGES] = '{
        REG_B, REG_D, REG_C, REG_E, REG_E, REG_E, REG_G,
        REG_G, REG_H, REG_F, REG_I, REG_H, REG_I
    };

    // Bit j set means region j is an already-assigned neighbor of this region.
    localparam logic [NUM_REGIONS-1:0] LOWER_NBR [NUM_REGIONS] = '{
        9'b000000000,
        9'b000000001,
        9'b000000010,
        9'b000000001,
        9'b000001110,
        9'b000010000,
        9'b000011000,
        9'b001010000,
        9'b010100000
    };
endpackage

// File: rtl/map_coloring_check.sv
// Full-map legality: valid is high when no edge joins two equal colors.
module map_coloring_check
    import map_color_pkg::*;
#(
    parameter int COLOR_W = 2
) (
    input  logic [NUM_REGIONS-1:0][COLOR_W-1:0] colors,
    output logic                                valid
);
    always_comb begin
        valid = 1'b1;
        for (int e = 0; e < NUM_EDGES; e++) begin
            if (colors[EDGE_U[e]] == colors[EDGE_V[e]]) valid = 1'b0;
        end
    end
endmodule

// File: rtl/map_color_solver.sv
// Backtracking 3x3 map colorer: one candidate per TRY cycle, regions A..I in order,
// candidates checked only against already-assigned neighbors.
module map_color_solver
    import map_color_pkg::*;
#(
    parameter int COLOR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COLOR_W-1:0] max_color,
    output logic [COLOR_W-1:0] A,
    output logic [COLOR_W-1:0] B,
    output logic [COLOR_W-1:0] C,
    output logic [COLOR_W-1:0] D,
    output logic [COLOR_W-1:0] E,
    output logic [COLOR_W-1:0] F,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] H,
    output logic [COLOR_W-1:0] I,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               valid,
    output logic [15:0]        steps
);
    localparam logic [COLOR_W-1:0] COLOR_ONE = 1;

    state_e                              state_q, state_d;
    logic [NUM_REGIONS-1:0][COLOR_W-1:0] colors_q, colors_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [COLOR_W-1:0]                  max_q, max_d;
    logic                                found_q, found_d;
    logic [15:0]                         steps_q, steps_d;
    logic                                cand_legal;
    logic [IDX_W-1:0]                    idx_next, idx_prev;

    assign idx_next = idx_q + 4'd1;
    assign idx_prev = idx_q - 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            colors_q <= '0;
            idx_q    <= '0;
            max_q    <= '0;
            found_q  <= 1'b0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            colors_q <= colors_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            found_q  <= found_d;
            steps_q  <= steps_d;
        end
    end

    always_comb begin
        cand_legal = 1'b1;
        for (int j = 0; j < NUM_REGIONS; j++) begin
            if (LOWER_NBR[idx_q][j] && colors_q[j] == colors_q[idx_q]) cand_legal = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        colors_d = colors_q;
        idx_d    = idx_q;
        max_d    = max_q;
        found_d  = found_q;
        steps_d  = steps_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    colors_d = '0;
                    idx_d    = '0;
                    max_d    = max_color;
                    steps_d  = '0;
                    found_d  = 1'b0;
                    state_d  = ST_TRY;
                end
            end
            ST_TRY: begin
                if (steps_q != 16'hFFFF) steps_d = steps_q + 16'd1;
                if (cand_legal) begin
                    if (idx_q == REG_I) begin
                        found_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d              = idx_next;
                        colors_d[idx_next] = '0;
                    end
                end else if (colors_q[idx_q] < max_q) begin
                    colors_d[idx_q] = colors_q[idx_q] + COLOR_ONE;
                end else begin
                    state_d = ST_BACKTRACK;
                end
            end
            ST_BACKTRACK: begin
                if (idx_q == REG_A) begin
                    found_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    colors_d[idx_q] = '0;
                    idx_d           = idx_prev;
                    // The parent's color decides whether we resume or keep unwinding.
                    if (colors_q[idx_prev] < max_q) begin
                        colors_d[idx_prev] = colors_q[idx_prev] + COLOR_ONE;
                        state_d            = ST_TRY;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_TRY) || (state_q == ST_BACKTRACK);
        done = (state_q == ST_DONE);
    end

    assign A     = colors_q[REG_A];
    assign B     = colors_q[REG_B];
    assign C     = colors_q[REG_C];
    assign D     = colors_q[REG_D];
    assign E     = colors_q[REG_E];
    assign F     = colors_q[REG_F];
    assign G     = colors_q[REG_G];
    assign H     = colors_q[REG_H];
    assign I     = colors_q[REG_I];
    assign found = found_q;
    assign steps = steps_q;

    map_coloring_check #(.COLOR_W(COLOR_W)) u_check (
        .colors (colors_q),
        .valid  (valid)
    );
endmodule

// File: tb/tb_map_color_solver.sv
// Bench for map_color_solver: a lexicographic-search model predicts coloring, found and
// step count; a negedge monitor checks every cycle's outputs against it.
module tb_map_color_solver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  max_color = 2'd0;
    logic [1:0]  A, B, C, D, E, F, G, H, I;
    logic        busy, done, found, valid;
    logic [15:0] steps;
    logic [8:0][1:0] cur;

    always #5 clk = ~clk;
    assign cur = {I, H, G, F, E, D, C, B, A};

    map_color_solver #(.COLOR_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .max_color(max_color),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H), .I(I),
        .busy(busy), .done(done), .found(found), .valid(valid), .steps(steps)
    );

    int EU [13] = '{0, 0, 1, 1, 2, 3, 3, 4, 4, 4, 5, 6, 7};
    int EV [13] = '{1, 3, 2, 4, 4, 4, 6, 6, 7, 5, 8, 7, 8};
    localparam logic [8:0][1:0] SOL2 = {2'd2, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};

    int drv_tests = 0, drv_fails = 0, mon_tests = 0, mon_fails = 0;
    int done_cnt = 0, busy_cycles = 0, done_at = 0;
    bit post_done = 1'b0;
    bit exp_found = 1'b0;
    logic [8:0][1:0] exp_cols = '0;
    int exp_steps = 0;

    // Regions 0..n-1 are mutually consistent on every edge inside that prefix.
    function automatic bit ok_prefix(input logic [8:0][1:0] c, input int n);
        for (int e = 0; e < 13; e++)
            if (EV[e] < n && c[EU[e]] == c[EV[e]]) return 1'b0;
        return 1'b1;
    endfunction

    // Solution = lexicographically first legal coloring (A most significant). A search
    // evaluates exactly the candidates whose prefix is legal and that do not lie past it.
    function automatic void model(input int m, output bit f, output logic [8:0][1:0] s,
                                  output int st);
        int base, sv;
        int pw [10];
        logic [8:0][1:0] t;
        base = m + 1;
        pw[0] = 1;
        for (int i = 1; i < 10; i++) pw[i] = pw[i-1] * base;
        f = 1'b0;
        s = '0;
        for (int v = 0; v < pw[9] && !f; v++) begin
            t = '0;
            for (int j = 0; j < 9; j++) t[j] = 2'((v / pw[8-j]) % base);
            if (ok_prefix(t, 9)) begin f = 1'b1; s = t; end
        end
        st = 0;
        for (int k = 0; k < 9; k++) begin
            sv = 0;
            for (int j = 0; j <= k; j++) sv += int'(s[j]) * pw[k-j];
            for (int v = 0; v < pw[k+1]; v++) begin
                t = '0;
                for (int j = 0; j <= k; j++) t[j] = 2'((v / pw[k-j]) % base);
                if (ok_prefix(t, k) && (!f || v <= sv)) st++;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        drv_tests++;
        if (act !== exp) begin
            drv_fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        mon_tests++;
        if (act !== exp) begin
            mon_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        mchk("valid", valid, ok_prefix(cur, 9));
        if (rst) begin
            post_done = 1'b0;
        end else begin
            if (busy) post_done = 1'b0;
            if (done) begin
                done_cnt++;
                mchk("done_busy", busy, 1'b0);
                mchk("done_found", found, exp_found);
                mchk("done_steps", steps, exp_steps);
                mchk("done_cols", cur, exp_cols);
                if (exp_found) mchk("done_valid", valid, 1'b1);
                post_done = 1'b1;
            end else if (post_done) begin
                mchk("hold_busy", busy, 1'b0);
                mchk("hold_found", found, exp_found);
                mchk("hold_steps", steps, exp_steps);
                mchk("hold_cols", cur, exp_cols);
            end
        end
    end

    task automatic wait_done(output bit seen);
        int n;
        seen = 1'b0;
        n = 1;
        busy_cycles = 0;
        while (n <= 2000) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) busy_cycles++;
            @(negedge clk);
            n++;
        end
        done_at = n;
        if (!seen) chk("timeout", 0, 1);
    endtask

    task automatic run_search(input int m, input bit hold, input int rst_at);
        bit f, seen;
        logic [8:0][1:0] s;
        int st, dc0;
        model(m, f, s, st);
        dc0 = done_cnt;
        @(negedge clk);
        max_color = 2'(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_found = f;
        exp_steps = st;
        exp_cols  = '0;
        if (f) exp_cols = s;
        else   exp_cols[0] = 2'(m);
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (rst_at != 0) begin
            for (int n = 1; n < rst_at && !done; n++) @(negedge clk);
            rst = 1'b1;
            start = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_found", found, 1'b0);
            chk("rst_steps", steps, 16'd0);
            chk("rst_cols", cur, 18'd0);
            @(negedge clk);
            chk("rst_idle", busy, 1'b0);
            if (rst_at < st) chk("rst_no_done", done_cnt, dc0);
            return;
        end
        wait_done(seen);
        if (hold) begin
            @(negedge clk);
            chk("hold_idle_busy", busy, 1'b0);
            chk("hold_idle_done", done, 1'b0);
            @(negedge clk);
            chk("hold_restart", busy, 1'b1);
            start = 1'b0;
            wait_done(seen);
            @(negedge clk);
            @(negedge clk);
            chk("hold_done_count", done_cnt, dc0 + 2);
        end else begin
            @(negedge clk);
            @(negedge clk);
            chk("done_count", done_cnt, dc0 + 1);
        end
    endtask

    initial begin
        bit f;
        logic [8:0][1:0] s;
        int st, m, ra;
        bit hd;

        model(2, f, s, st);
        chk("model2_found", f, 1'b1);
        chk("model2_cols", s, SOL2);
        chk("model2_steps", st, 16);
        model(0, f, s, st);
        chk("model0_found", f, 1'b0);
        chk("model0_steps", st, 2);
        model(1, f, s, st);
        chk("model1_found", f, 1'b0);

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_found", found, 1'b0);
        chk("reset_steps", steps, 16'd0);
        chk("reset_cols", cur, 18'd0);
        rst = 1'b0;

        run_search(2, 1'b0, 0);
        chk("m2_busy_cycles", busy_cycles, 16);
        chk("m2_done_cycle", done_at, 17);
        chk("m2_cols", cur, SOL2);
        chk("m2_steps", steps, 16'd16);
        chk("m2_found", found, 1'b1);
        chk("m2_valid", valid, 1'b1);

        run_search(3, 1'b0, 0);
        chk("m3_cols", cur, SOL2);
        chk("m3_steps", steps, 16'd16);
        chk("m3_found", found, 1'b1);

        run_search(0, 1'b0, 0);
        chk("m0_steps", steps, 16'd2);
        chk("m0_found", found, 1'b0);
        chk("m0_cols", cur, 18'd0);

        run_search(1, 1'b0, 0);
        chk("m1_found", found, 1'b0);
        chk("m1_busy", busy, 1'b0);

        run_search(2, 1'b0, 5);
        run_search(2, 1'b0, 0);
        chk("after_rst_cols", cur, SOL2);
        chk("after_rst_steps", steps, 16'd16);

        run_search(2, 1'b1, 0);
        chk("held_cols", cur, SOL2);

        for (int r = 0; r < 10; r++) begin
            m  = int'($urandom_range(0, 3));
            hd = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : 0;
            run_search(m, hd, ra);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", drv_tests + mon_tests, drv_fails + mon_fails);
        $finish;
    end
endmodule
